// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache
// sitting in the MEM stage; stalls the pipeline via data_hit while memory is busy.
module dcache_ctrl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        data_hit,
  output logic        mm_req,
  output logic        mm_we,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  input  logic        mm_ack
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RFILL = 2'd1,
    S_WTHRU = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_next_state;
  logic               r_done;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_issue_rd;
  logic               w_issue_wr;
  logic               w_txn_done;
  logic               w_fill;
  logic               w_wr_upd;
  logic               w_unused;

  assign w_idx    = addr[IDX_W+1:2];
  assign w_tag    = addr[31:IDX_W+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = ^addr[1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a just-finished store gets one idle cycle before re-arbitration
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_done) begin
          w_next_state = S_IDLE;
        end else if (mem_write) begin
          w_next_state = S_WTHRU;
        end else if (mem_read && !w_hit) begin
          w_next_state = S_RFILL;
        end
      end
      S_RFILL: if (mm_ack) w_next_state = S_IDLE;
      S_WTHRU: if (mm_ack) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Pipeline-facing outputs and internal strobes
  always_comb begin
    data_hit   = 1'b0;
    read_data  = 32'h0;
    w_issue_rd = 1'b0;
    w_issue_wr = 1'b0;
    w_txn_done = 1'b0;
    w_fill     = 1'b0;
    w_wr_upd   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_done) begin
          data_hit = 1'b1;
        end else if (mem_write) begin
          w_issue_wr = 1'b1;
        end else if (mem_read) begin
          data_hit   = w_hit;
          read_data  = w_hit ? r_data[w_idx] : 32'h0;
          w_issue_rd = !w_hit;
        end else begin
          data_hit = 1'b1;
        end
      end
      S_RFILL: begin
        w_txn_done = mm_ack;
        w_fill     = mm_ack;
      end
      S_WTHRU: begin
        w_txn_done = mm_ack;
        w_wr_upd   = mm_ack && w_hit;
      end
      default: ;
    endcase
  end

  // Memory-side request registers, held until the acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_req   <= 1'b0;
      mm_we    <= 1'b0;
      mm_addr  <= 32'h0;
      mm_wdata <= 32'h0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_WTHRU) && mm_ack;
      if (w_issue_wr) begin
        mm_req   <= 1'b1;
        mm_we    <= 1'b1;
        mm_addr  <= {addr[31:2], 2'b00};
        mm_wdata <= write_data;
      end else if (w_issue_rd) begin
        mm_req  <= 1'b1;
        mm_we   <= 1'b0;
        mm_addr <= {addr[31:2], 2'b00};
      end else if (w_txn_done) begin
        mm_req <= 1'b0;
        mm_we  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mm_rdata;
    end else if (w_wr_upd) begin
      r_data[w_idx] <= write_data;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios then random traffic, checked against
// an address-keyed model of cache contents with direct-mapped eviction.
module tb_dcache_ctrl;
  localparam int unsigned LINES = 16;
  localparam int unsigned IDX_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        data_hit;
  logic        mm_req;
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_ack;

  int n_checks = 0;
  int n_err    = 0;

  // Word address -> cached word; presence means the access would hit
  logic [31:0] m_cache [int unsigned];

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .data_hit(data_hit), .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr),
    .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_ack(mm_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
    int unsigned wa = int'(a >> 2);
    int unsigned victim = 0;
    bit found = 1'b0;
    foreach (m_cache[k]) begin
      if ((k % LINES) == (wa % LINES)) begin
        victim = k;
        found  = 1'b1;
      end
    end
    if (found) m_cache.delete(victim);
    m_cache[wa] = d;
  endtask

  task automatic do_idle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    chk("idle_hit", 32'(data_hit), 32'd1);
    chk("idle_rdata", read_data, 32'h0);
  endtask

  task automatic do_load(input logic [31:0] a, input int lat, input logic [31:0] rd);
    int unsigned wa = int'(a >> 2);
    logic [31:0] ma = {a[31:2], 2'b00};
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = a; write_data = $urandom;
    #1;
    if (m_cache.exists(wa)) begin
      chk("ld_hit", 32'(data_hit), 32'd1);
      chk("ld_hit_data", read_data, m_cache[wa]);
      chk("ld_hit_noreq", 32'(mm_req), 32'd0);
    end else begin
      chk("ld_miss_stall", 32'(data_hit), 32'd0);
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        mm_ack   = (k == lat);
        mm_rdata = (k == lat) ? rd : $urandom;
        #1;
        chk("rf_req", 32'(mm_req), 32'd1);
        chk("rf_we", 32'(mm_we), 32'd0);
        chk("rf_addr", mm_addr, ma);
        chk("rf_stall", 32'(data_hit), 32'd0);
      end
      @(negedge clk);
      mm_ack = 1'b0; mm_rdata = $urandom;
      #1;
      m_fill(a, rd);
      chk("ld_fill_hit", 32'(data_hit), 32'd1);
      chk("ld_fill_data", read_data, rd);
      chk("ld_fill_noreq", 32'(mm_req), 32'd0);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat, input bit both);
    int unsigned wa = int'(a >> 2);
    logic [31:0] ma = {a[31:2], 2'b00};
    @(negedge clk);
    mem_write = 1'b1; mem_read = both; addr = a; write_data = d;
    #1;
    chk("st_stall", 32'(data_hit), 32'd0);
    chk("st_noreq_yet", 32'(mm_req), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      mm_ack   = (k == lat);
      mm_rdata = $urandom;
      #1;
      chk("wt_req", 32'(mm_req), 32'd1);
      chk("wt_we", 32'(mm_we), 32'd1);
      chk("wt_addr", mm_addr, ma);
      chk("wt_wdata", mm_wdata, d);
      chk("wt_stall", 32'(data_hit), 32'd0);
    end
    @(negedge clk);
    mm_ack = 1'b0;
    #1;
    if (m_cache.exists(wa)) m_cache[wa] = d;
    chk("st_done_hit", 32'(data_hit), 32'd1);
    chk("st_done_noreq", 32'(mm_req), 32'd0);
    chk("st_done_we", 32'(mm_we), 32'd0);
  endtask

  task automatic stray_ack();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; mm_ack = 1'b1; mm_rdata = $urandom;
    #1;
    chk("stray_hit", 32'(data_hit), 32'd1);
    chk("stray_noreq", 32'(mm_req), 32'd0);
    @(negedge clk);
    mm_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int op;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0;
    write_data = 32'h0; mm_rdata = 32'h0; mm_ack = 1'b0;
    #1;
    chk("rst_mm_req", 32'(mm_req), 32'd0);
    chk("rst_mm_we", 32'(mm_we), 32'd0);
    chk("rst_mm_addr", mm_addr, 32'h0);
    chk("rst_mm_wdata", mm_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_idle();

    do_load(32'h40, 3, 32'hDEADBEEF);
    do_load(32'h40, 1, 32'h0);
    do_store(32'h40, 32'h12345678, 2, 1'b0);
    do_load(32'h40, 1, 32'h0);
    do_store(32'h80, 32'hAAAA5555, 1, 1'b0);
    do_load(32'h40, 1, 32'h0);
    do_load(32'h80, 2, 32'h0BADF00D);
    stray_ack();
    do_load(32'h80, 1, 32'h0);
    do_store(32'h44, 32'h5A5A0001, 2, 1'b1);
    do_load(32'h44, 1, 32'h44440044);
    do_idle();

    // Reset while a fill is outstanding
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h140;
    #1;
    chk("rstfill_miss", 32'(data_hit), 32'd0);
    @(negedge clk);
    #1;
    chk("rstfill_req", 32'(mm_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstfill_req_drop", 32'(mm_req), 32'd0);
    chk("rstfill_addr_clr", mm_addr, 32'h0);
    @(negedge clk);
    mm_ack = 1'b1; mm_rdata = 32'hFFFF0000;
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    mm_ack = 1'b0;
    #1;
    chk("rstfill_idle_req", 32'(mm_req), 32'd0);
    chk("rstfill_idle_hit", 32'(data_hit), 32'd1);
    m_cache.delete();
    do_load(32'h40, 2, 32'hCAFEBABE);
    do_load(32'h140, 1, 32'h01400140);

    for (int n = 0; n < 200; n++) begin
      a = ((32'($urandom_range(0, 2))) << (IDX_W + 2)) |
          ((32'($urandom_range(0, LINES - 1))) << 2) |
          32'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op < 5)       do_load(a, $urandom_range(1, 4), $urandom);
      else if (op < 7)  do_store(a, $urandom, $urandom_range(1, 4), 1'b0);
      else if (op == 7) do_store(a, $urandom, $urandom_range(1, 4), 1'b1);
      else if (op == 8) do_idle();
      else              stray_ack();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
